// File: rtl/wb_master_xfer.sv
// Wishbone B4 classic-cycle block master: incrementing-address read/write bursts with
// ACK/ERR/RTY handling. Define WB_MASTER_XFER_TIMEOUT_EN to abort a silent STROBE phase.
module wb_master_xfer #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned LEN_W     = 8,
    parameter int unsigned MAX_RETRY = 3,
`ifdef WB_MASTER_XFER_TIMEOUT_EN
    parameter int unsigned TIMEOUT   = 255,
`endif
    localparam int unsigned SEL_W    = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic              cmd_we_i,
    input  logic [ADDR_W-1:0] cmd_adr_i,
    input  logic [SEL_W-1:0]  cmd_sel_i,
    input  logic [LEN_W-1:0]  cmd_len_i,

    input  logic [DATA_W-1:0] wdat_i,
    input  logic              wdat_valid_i,
    output logic              wdat_ready_o,

    output logic [DATA_W-1:0] rdat_o,
    output logic              rdat_valid_o,

    output logic              done_o,
    output logic [1:0]        status_o,
    output logic [LEN_W:0]    beats_o,

    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [SEL_W-1:0]  sel_o,
    output logic [DATA_W-1:0] dat_o,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              ack_i,
    input  logic              err_i,
    input  logic              rty_i
);

    localparam int unsigned RtyW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [1:0] StsOk  = 2'd0;
    localparam logic [1:0] StsErr = 2'd1;
    localparam logic [1:0] StsRty = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StWaitWdat,
        StStrobe,
        StRetryGap,
        StFinish
    } state_e;

    state_e              state_q, state_d;
    logic                cyc_q, cyc_d;
    logic                stb_q, stb_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [LEN_W:0]      beat_q, beat_d;
    logic [RtyW-1:0]     rty_q, rty_d;
    logic [DATA_W-1:0]   rdat_q, rdat_d;
    logic                rdat_valid_q, rdat_valid_d;
    logic                done_q, done_d;
    logic [1:0]          status_q, status_d;
    logic [LEN_W:0]      beats_q, beats_d;

`ifdef WB_MASTER_XFER_TIMEOUT_EN
    localparam int unsigned ToW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [1:0]  StsTimeout = 2'd3;

    logic [ToW-1:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        adr_d        = adr_q;
        sel_d        = sel_q;
        dat_d        = dat_q;
        len_d        = len_q;
        beat_d       = beat_q;
        rty_d        = rty_q;
        rdat_d       = rdat_q;
        rdat_valid_d = 1'b0;
        status_d     = status_q;
        beats_d      = beats_q;
`ifdef WB_MASTER_XFER_TIMEOUT_EN
        to_cnt_d     = '0;
`endif

        unique case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    we_d    = cmd_we_i;
                    adr_d   = cmd_adr_i;
                    sel_d   = cmd_sel_i;
                    len_d   = cmd_len_i;
                    beat_d  = '0;
                    rty_d   = '0;
                    state_d = cmd_we_i ? StWaitWdat : StStrobe;
                end
            end
            StWaitWdat: begin
                if (wdat_valid_i) begin
                    dat_d   = wdat_i;
                    state_d = StStrobe;
                end
            end
            StStrobe: begin
                // Termination priority: ERR over RTY over ACK.
                if (err_i) begin
                    status_d = StsErr;
                    beats_d  = beat_q;
                    state_d  = StFinish;
                end else if (rty_i) begin
                    if (32'(rty_q) < MAX_RETRY) begin
                        rty_d   = rty_q + 1'b1;
                        state_d = StRetryGap;
                    end else begin
                        status_d = StsRty;
                        beats_d  = beat_q;
                        state_d  = StFinish;
                    end
                end else if (ack_i) begin
                    beat_d = beat_q + 1'b1;
                    rty_d  = '0;
                    adr_d  = adr_q + ADDR_W'(SEL_W);
                    if (!we_q) begin
                        rdat_d       = dat_i;
                        rdat_valid_d = 1'b1;
                    end
                    if (beat_q == {1'b0, len_q}) begin
                        status_d = StsOk;
                        beats_d  = beat_d;
                        state_d  = StFinish;
                    end else if (we_q) begin
                        state_d = StWaitWdat;
                    end
                end
`ifdef WB_MASTER_XFER_TIMEOUT_EN
                else if (32'(to_cnt_q) == TIMEOUT - 1) begin
                    status_d = StsTimeout;
                    beats_d  = beat_q;
                    state_d  = StFinish;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
`endif
            end
            StRetryGap: begin
                state_d = StStrobe;
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Bus strobes are registered from the next state so they never glitch.
        cyc_d  = (state_d == StWaitWdat) || (state_d == StStrobe) || (state_d == StRetryGap);
        stb_d  = (state_d == StStrobe);
        done_d = (state_d == StFinish);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            sel_q        <= '0;
            dat_q        <= '0;
            len_q        <= '0;
            beat_q       <= '0;
            rty_q        <= '0;
            rdat_q       <= '0;
            rdat_valid_q <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= '0;
            beats_q      <= '0;
`ifdef WB_MASTER_XFER_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            sel_q        <= sel_d;
            dat_q        <= dat_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            rty_q        <= rty_d;
            rdat_q       <= rdat_d;
            rdat_valid_q <= rdat_valid_d;
            done_q       <= done_d;
            status_q     <= status_d;
            beats_q      <= beats_d;
`ifdef WB_MASTER_XFER_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign cmd_ready_o  = (state_q == StIdle);
    assign wdat_ready_o = (state_q == StWaitWdat);
    assign rdat_o       = rdat_q;
    assign rdat_valid_o = rdat_valid_q;
    assign done_o       = done_q;
    assign status_o     = status_q;
    assign beats_o      = beats_q;
    assign cyc_o        = cyc_q;
    assign stb_o        = stb_q;
    assign we_o         = we_q;
    assign adr_o        = adr_q;
    assign sel_o        = sel_q;
    assign dat_o        = dat_q;

endmodule

// File: doc/wb_master_xfer.md
# wb_master_xfer

Parametrised Wishbone B4 classic-cycle bus master that replaces the trigger-only NOP master with real transfers. It accepts a command (read/write, start address, beat count, byte select), runs a classic block cycle of incrementing-address beats, and reports completion status. It handles ACK, ERR and RTY terminations, with a bounded retry count and an optional timeout. It sits between a local controller (CPU shim, test sequencer, DMA front end) and a Wishbone interconnect master port.

## Interface
- ADDR_W, 32, address width (byte address)
- DATA_W, 32, data width; multiple of 8
- SEL_W, DATA_W/8, byte-select width; derived, do not override
- LEN_W, 8, beat-count field width
- MAX_RETRY, 3, RTY terminations tolerated per beat
- TIMEOUT, 255, cycles without termination before abort (only with macro)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  reset; synchronous, active-low
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake
- cmd_we_i  in  1  1 = write, 0 = read
- cmd_adr_i  in  ADDR_W  start address
- cmd_sel_i  in  SEL_W  byte select applied to every beat
- cmd_len_i  in  LEN_W  beats minus one
- wdat_i  in  DATA_W  write data for the current beat
- wdat_valid_i / wdat_ready_o  in/out  1  write-data handshake
- rdat_o  out  DATA_W  read data
- rdat_valid_o  out  1  one-cycle strobe; no backpressure
- done_o  out  1  one-cycle pulse at command end
- status_o  out  2  0 OK, 1 ERR, 2 RETRY_EXHAUSTED, 3 TIMEOUT; held until next done_o
- beats_o  out  LEN_W+1  beats acknowledged in the last command; held
- cyc_o, stb_o, we_o  out  1  Wishbone
- adr_o  out  ADDR_W  Wishbone
- sel_o  out  SEL_W  Wishbone
- dat_o  out  DATA_W  Wishbone
- dat_i  in  DATA_W  Wishbone
- ack_i, err_i, rty_i  in  1  Wishbone

## Operation
- States:
  - IDLE: cmd_ready_o=1. A handshake latches the command, sets cyc_o=1 and we_o, and loads adr_o and sel_o. Next state is WAIT_WDAT for writes, STROBE for reads.
  - WAIT_WDAT: cyc_o=1, stb_o=0, wdat_ready_o=1. On wdat_valid_i, latch dat_o, set stb_o=1, go to STROBE.
  - STROBE: stb_o=1. Termination priority is err_i > rty_i > ack_i.
    - ack_i: increment beat counter; adr_o += SEL_W (wraps mod 2^ADDR_W). For reads, rdat_o=dat_i and rdat_valid_o=1 at the next edge. If this was the last beat, go to FINISH with OK. Otherwise, reads keep stb_o high and go to the next beat; writes drop stb_o and go to WAIT_WDAT.
    - rty_i: if the retry count is below MAX_RETRY, increment it, drop stb_o and go to RETRY_GAP. Otherwise go to FINISH with RETRY_EXHAUSTED.
    - err_i: go to FINISH with ERR.
  - RETRY_GAP: one cycle with stb_o=0 and cyc_o=1, then STROBE with the same adr_o and dat_o.
  - FINISH: cyc_o=0, stb_o=0, done_o=1, status_o and beats_o updated, then IDLE.
- The retry counter clears on each acknowledged beat. Aborts do not count the failed beat in beats_o.
- cmd_len_i=2^LEN_W-1 gives 2^LEN_W beats; beats_o is LEN_W+1 bits wide to hold that count.

## Timing
- Reset (rst_ni=0 at an edge), including mid-cycle: all Wishbone outputs, rdat_o, status_o and beats_o go to 0; rdat_valid_o, done_o and wdat_ready_o go to 0; cmd_ready_o goes to 1; state goes to IDLE. No done_o pulse is produced for the interrupted command.
- Command accepted at edge T: cyc_o=1 from T+1.
  - Read: stb_o=1 from T+1.
  - Write: stb_o=1 one cycle after the wdat handshake.
- Read beats stream at 1 beat/cycle with zero-wait ACK. Write beats take 2 cycles minimum (WAIT_WDAT plus STROBE).
- Last ACK at edge E: stb_o=0 from E+1, done_o high E+1 to E+2, cyc_o=0 from E+1, cmd_ready_o=1 from E+2.
- ack_i, err_i and rty_i are ignored outside STROBE.
- cmd_valid_i is ignored while not in IDLE.

## Configuration
- WB_MASTER_XFER_TIMEOUT_EN defined:
  - A counter clears on entry to STROBE and increments each STROBE cycle without termination.
  - When it reaches TIMEOUT, go to FINISH with status TIMEOUT.
  - A termination arriving in the same cycle wins over the timeout.
- Not defined: the master waits indefinitely in STROBE, and status 3 is never produced.

## Test plan
- Read, adr=0x100, len=3, slave ACKs every cycle with dat_i=0x11,0x22,0x33,0x44 -> adr_o=0x100/104/108/10C on consecutive cycles; rdat_valid_o x4 with matching data; done_o with status 0 and beats_o=4.
- Write, len=1, wdat 0xDEADBEEF then 0xCAFEF00D with a 2-cycle wdat_valid_i delay -> stb_o low during the delay; dat_o matches per beat; status 0, beats_o=2.
- Read, slave RTYs 3 times then ACKs (MAX_RETRY=3) -> three one-cycle stb_o gaps with adr_o unchanged; status 0. A fourth RTY instead -> status 2, beats_o=0.
- Read, len=2, err_i on beat 1 with ack_i also high -> ERR wins; status 1, beats_o=1, cyc_o low the next cycle.
- With macro and TIMEOUT=5, slave silent -> done_o exactly 5 cycles after stb_o rises, status 3. Without macro -> stb_o stays high indefinitely.
- rst_ni low for one cycle during beat 2 of a len=3 read -> cyc_o=0 and stb_o=0 the next cycle, no done_o, cmd_ready_o=1.
